div_share_ctrl: RTL

Controller that time-shares a single iterative non-restoring divider among `NUM_REQ` requesters inside the RSA decryption datapath. Typical requesters are the modular-exponentiation reduction step and the key-setup path. It arbitrates round-robin, captures the winner's operands, sequences the divider's `start`/`done` handshake, and returns quotient and remainder to the winning requester. It also short-circuits divide-by-zero and guards against the divider having no reset.

---
 rtl/div_share_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin time-sharing of one iterative divider among NUM_REQ requesters.
// Latency: req->rsp_valid = D+4 cycles (D = divider start->done), divide-by-zero 3 cycles.
// Backpressure: requesters hold req/operands until gnt; one job in flight, others wait in req.
//
// Ports: req/req_dividend/req_divisor (flattened, slice i = [i*WIDTH +: WIDTH]) in,
//        gnt/rsp_valid one-hot pulses, rsp_quot/rsp_rem/rsp_dbz shared result bus, busy,
//        div_start/div_q/div_m/div_done/div_quot/div_rem to the shared divider.
module div_share_ctrl #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 4097,
  parameter int FLUSH_CYCLES = 4100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quot,
  output logic [WIDTH-1:0]         rsp_rem,
  output logic                     rsp_dbz,
  output logic                     busy,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_q,
  output logic [WIDTH-1:0]         div_m,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_quot,
  input  logic [WIDTH-1:0]         div_rem
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RESP_DBZ
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_dvd;
  logic [WIDTH-1:0] pick_dvs;

  // (base + k) mod NUM_REQ without a divider; k is always < NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req[wrap_idx(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(rr_ptr, k);
      end
    end
    pick_dvd = req_dividend[int'(pick_idx)*WIDTH +: WIDTH];
    pick_dvs = req_divisor[int'(pick_idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FLUSH;
      flush_cnt <= CNT_W'(FLUSH_CYCLES);
      rr_ptr    <= '0;
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
      busy      <= 1'b0;
      div_start <= 1'b0;
      div_q     <= '0;
      div_m     <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_dbz   <= 1'b0;
      div_start <= 1'b0;
      busy      <= 1'b1;
      case (state)
        // The divider has no reset and ignores start while busy, so a run left
        // in flight across reset must drain before we may issue a new one.
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        // Not granting while rsp_valid is out means a req still high after the
        // response is judged one cycle later, as a fresh request.
        S_IDLE: begin
          if (pick_vld && rsp_valid == '0) begin
            gnt    <= NUM_REQ'(1) << pick_idx;
            div_q  <= pick_dvd;
            div_m  <= pick_dvs;
            owner  <= pick_idx;
            rr_ptr <= wrap_idx(pick_idx, 1);
            state  <= S_ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (div_m == '0) begin
            state <= S_RESP_DBZ;
          end else begin
            div_start <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_done) begin
            rsp_quot <= div_quot;
            rsp_rem  <= div_rem;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= S_IDLE;
          busy      <= 1'b0;
        end
        S_RESP_DBZ: begin
          rsp_valid <= NUM_REQ'(1) << owner;
          rsp_dbz   <= 1'b1;
          rsp_quot  <= '1;
          rsp_rem   <= div_q;
          state     <= S_IDLE;
          busy      <= 1'b0;
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

endmodule
